// File: rtl/ha_bist_ctrl.sv
// Half-adder BIST: drives 00,01,10,11 NUM_LOOPS times, checks Sum/Cout after SETTLE_CYCLES; (SETTLE_CYCLES+2) cycles per vector.
// No backpressure (start is ignored while busy). Optional first-fail log under `HA_BIST_LOG_EN.
module ha_bist_ctrl #(
  parameter int NUM_LOOPS     = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             Sum,
  input  logic             Cout,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
`ifdef HA_BIST_LOG_EN
  ,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [1:0]       first_fail_obs
`endif
);

  localparam int                LOOP_W    = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(NUM_LOOPS - 1);
  localparam logic [7:0]        SETTLE    = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        vec;
  logic [LOOP_W-1:0] loop_cnt;
  logic [7:0]        settle_cnt;
  logic              mismatch, last_vec, accept, running, kill;
  logic [ERR_W-1:0]  err_inc, err_nxt;

  always_comb begin
    mismatch = (Sum != (A ^ B)) || (Cout != (A & B));
    err_inc  = (&err_count) ? err_count : err_count + ERR_W'(1);
    err_nxt  = mismatch ? err_inc : err_count;
    last_vec = (vec == 2'd3) && (loop_cnt == LOOP_LAST);
    running  = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    accept   = start && ((state == IDLE) || (state == DONE));
    kill     = abort && running;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      state_nxt = (SETTLE == 8'd0) ? CHECK : WAIT;
      // settle_cnt reaches zero on the edge that leaves WAIT
      WAIT:       if (settle_cnt <= 8'd1) state_nxt = CHECK;
      CHECK:      state_nxt = last_vec ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A          <= 1'b0;
      B          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      vec        <= '0;
      loop_cnt   <= '0;
      settle_cnt <= '0;
`ifdef HA_BIST_LOG_EN
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_obs   <= '0;
`endif
    end else if (accept) begin
      err_count <= '0;
      fail_vec  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec       <= '0;
      loop_cnt  <= '0;
      busy      <= 1'b1;
`ifdef HA_BIST_LOG_EN
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_obs   <= '0;
`endif
    end else if (kill) begin
      // error state is left intact so a cancelled run can still be inspected
      busy <= 1'b0;
      done <= 1'b0;
      A    <= 1'b0;
      B    <= 1'b0;
    end else begin
      case (state)
        DRIVE: begin
          A          <= vec[1];
          B          <= vec[0];
          settle_cnt <= SETTLE;
        end
        WAIT: settle_cnt <= settle_cnt - 8'd1;
        CHECK: begin
          if (mismatch) begin
            err_count     <= err_inc;
            fail_vec[vec] <= 1'b1;
`ifdef HA_BIST_LOG_EN
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
              first_fail_obs   <= {Sum, Cout};
            end
`endif
          end
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_nxt == '0);
          end else if (vec == 2'd3) begin
            vec      <= '0;
            loop_cnt <= loop_cnt + LOOP_W'(1);
          end else begin
            vec <= vec + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
